ad_sample_sync: RTL and testbench
=================================

Name: ad_sample_sync

Overview:
- Sits between the AD1868 serial capture stage (8 MHz domain) and the I2S encoder (24.576 MHz MCLK domain).
- Synchronises the asynchronous latch strobe into the MCLK domain and captures the stable 16-bit L/R words on each detected latch edge.
- Buffers captured pairs in a small FIFO and hands them to the encoder through a valid/ready handshake.
- Flags overrun and underrun, and repeats the last sample when starved.

Parameters:
- SYNC_STAGES, 2, number of flops in the latch synchroniser (>=2).
- DEPTH, 4, FIFO entries holding {L,R} pairs; power of two, >=2.
- LATCH_RISING, 1, 1 = capture on latch rising edge; 0 = capture on falling edge.

Ports:
- i_clk  in  1  MCLK, 24.576 MHz; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_latch  in  1  latch strobe from AD domain; asynchronous to i_clk.
- i_data_l  in  16  left sample from capture stage; stable for >=8 i_clk cycles after the latch edge.
- i_data_r  in  16  right sample; same stability guarantee as i_data_l.
- o_data_l  out  16  left sample at FIFO head (or last popped sample when empty).
- o_data_r  out  16  right sample at FIFO head (or last popped sample when empty).
- o_valid  out  1  FIFO non-empty.
- i_ready  in  1  encoder accepts the current pair.
- o_level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- o_overrun  out  1  sticky: a capture was dropped because the FIFO was full.
- o_underrun  out  1  sticky: i_ready was high while o_valid was low.

Behaviour:
- Reset (sync, i_rst=1 at a clock edge) clears the following:
  - o_valid=0, o_level=0, o_overrun=0, o_underrun=0, o_data_l=o_data_r=0.
  - FIFO pointers and the last-sample register.
  - Synchroniser chain and edge-history flop, both cleared to 0.
- Arming: edge detection is suppressed for SYNC_STAGES+1 cycles after reset deasserts. Consequence: a latch held high through reset produces no spurious capture.
- Synchroniser: i_latch passes through SYNC_STAGES flops. The edge detect compares the last sync stage with a history flop.
- Edge pulse is one cycle wide; polarity is selected by LATCH_RISING.
- Capture: in the cycle after the edge pulse, {i_data_l,i_data_r} is written into the FIFO. The data bus is deliberately not synchronised; it is safe because of the stability guarantee.
- Latency: i_latch edge first sampled at clock edge 0 -> edge pulse after edge SYNC_STAGES -> o_valid=1 after edge SYNC_STAGES+1 (3 cycles at default).
- Pop: occurs on any clock with o_valid && i_ready. The head advances and the popped pair is copied into the last-sample register.
- Outputs:
  - o_data_l/r = FIFO head when o_valid=1.
  - Otherwise o_data_l/r = last-sample register, so the encoder repeats the last sample.
- Full, push without pop: the new pair is dropped, o_overrun is set, and FIFO contents are unchanged.
- Full, push with simultaneous pop: both are performed; no overrun; o_level is unchanged.
- Empty, push: o_valid rises next cycle. i_ready that same cycle is an underrun; no pop occurs.
- Empty, i_ready=1: no pop, o_underrun is set, and outputs hold the last sample.
- Pointers wrap modulo DEPTH.
- o_level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Sticky flags clear only on reset.
- Reset asserted mid-transfer: FIFO contents are discarded, and the first post-reset capture requires a fresh edge after arming.

Test Plan:
- Reset, then one latch rising edge with L=0x1234, R=0xABCD, i_ready=0 -> o_valid=1 exactly 3 cycles after the edge is sampled; o_data=0x1234/0xABCD; o_level=1.
- Five latches with L=1..5, i_ready=0, DEPTH=4 -> o_level=4, o_overrun=1; popping yields L=1,2,3,4 in order; L=5 is absent.
- FIFO full, latch edge captured in the same cycle as a pop -> o_level stays 4, o_overrun stays 0, and the new sample appears last.
- Single sample 0x7FFF popped, then i_ready held high with no latches -> o_valid=0, o_underrun=1, o_data_l stays 0x7FFF.
- i_latch held high across reset release -> no capture, o_level=0. The next real rising edge is captured normally.
- LATCH_RISING=0 and random i_latch phase vs i_clk over 1000 frames with i_ready pulsed once per frame -> no data loss or duplication, both flags 0.

Source files
------------

// File: rtl/ad_sample_sync.sv
// rtl/ad_sample_sync.sv - latch-strobe synchroniser and {L,R} sample FIFO into the MCLK domain
// Captures the unsynchronised data bus on each detected latch edge and hands pairs over valid/ready.

module ad_sample_sync #(
  parameter int SYNC_STAGES  = 2,
  parameter int DEPTH        = 4,
  parameter bit LATCH_RISING = 1'b1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_latch,
  input  logic [15:0]              i_data_l,
  input  logic [15:0]              i_data_r,
  output logic [15:0]              o_data_l,
  output logic [15:0]              o_data_r,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overrun,
  output logic                     o_underrun
);

  localparam int AW      = $clog2(DEPTH);
  localparam int LW      = AW + 1;
  localparam int ARM_CYC = SYNC_STAGES + 1;
  localparam int CW      = $clog2(ARM_CYC + 1);

  localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [CW-1:0] ARM_DONE = CW'(ARM_CYC);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   edge_q;
  logic [CW-1:0]          arm_cnt_q;

  logic [31:0]            mem_q [DEPTH];
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]          level_q, level_d;
  logic [31:0]            last_q, last_d;
  logic                   overrun_q, overrun_d;
  logic                   underrun_q, underrun_d;

  logic                   sync_last;
  logic                   edge_det;
  logic                   armed;
  logic                   valid;
  logic                   full;
  logic                   push;
  logic                   pop;
  logic                   do_write;
  logic [31:0]            head;

  assign sync_last = sync_q[SYNC_STAGES-1];
  assign edge_det  = LATCH_RISING ? (sync_last & ~hist_q) : (~sync_last & hist_q);
  // Edges are ignored until the chain has flushed, so a latch held through reset is not seen.
  assign armed     = (arm_cnt_q == ARM_DONE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      edge_q    <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], i_latch};
      hist_q    <= sync_last;
      edge_q    <= edge_det & armed;
      if (!armed) begin
        arm_cnt_q <= arm_cnt_q + CNT_ONE;
      end
    end
  end

  assign valid    = (level_q != '0);
  assign full     = (level_q == FULL_LVL);
  assign push     = edge_q;
  assign pop      = valid & i_ready;
  assign do_write = push & (~full | pop);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    last_d     = last_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;

    if (do_write) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      last_d   = head;
    end
    case ({do_write, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (push && full && !pop) begin
      overrun_d = 1'b1;
    end
    if (i_ready && !valid) begin
      underrun_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      last_q     <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      last_q     <= last_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  // The data bus is sampled raw; it is held stable well past the synchronised edge.
  always_ff @(posedge i_clk) begin
    if (!i_rst && do_write) begin
      mem_q[wr_ptr_q] <= {i_data_l, i_data_r};
    end
  end

  assign o_valid    = valid;
  assign o_data_l   = valid ? head[31:16] : last_q[31:16];
  assign o_data_r   = valid ? head[15:0]  : last_q[15:0];
  assign o_level    = level_q;
  assign o_overrun  = overrun_q;
  assign o_underrun = underrun_q;

endmodule

// File: tb/tb_ad_sample_sync.sv
// tb/tb_ad_sample_sync.sv - scoreboard bench for ad_sample_sync (rising and falling capture)

module tb_ad_sample_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        latch, ready;
  logic [15:0] dl, dr, ol, orr;
  logic        valid, ovr, unr;
  logic [2:0]  level;

  logic        latch_f, ready_f;
  logic [15:0] dl_f, dr_f, ol_f, or_f;
  logic        valid_f, ovr_f, unr_f;
  logic [2:0]  level_f;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] sb_f[$];

  always #5 clk = ~clk;

  ad_sample_sync dut (
    .i_clk(clk), .i_rst(rst), .i_latch(latch), .i_data_l(dl), .i_data_r(dr),
    .o_data_l(ol), .o_data_r(orr), .o_valid(valid), .i_ready(ready),
    .o_level(level), .o_overrun(ovr), .o_underrun(unr)
  );

  ad_sample_sync #(.LATCH_RISING(1'b0)) dut_f (
    .i_clk(clk), .i_rst(rst), .i_latch(latch_f), .i_data_l(dl_f), .i_data_r(dr_f),
    .o_data_l(ol_f), .o_data_r(or_f), .o_valid(valid_f), .i_ready(ready_f),
    .o_level(level_f), .o_overrun(ovr_f), .o_underrun(unr_f)
  );

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; ready = 1'b0; ready_f = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(6);
    sb.delete();
    sb_f.delete();
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input bit accept);
    dl = l; dr = r; latch = 1'b1;
    if (accept) sb.push_back({l, r});
    tick(4);
    latch = 1'b0;
    tick(5);
  endtask

  task automatic pop_all(input string tag);
    for (int k = 0; k < 6; k++) begin
      if (valid) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL %s_extra: got %h%h expected nothing", tag, ol, orr);
        end else begin
          if ({ol, orr} !== sb[0]) begin
            errors++;
            $display("FAIL %s_data: got %h%h expected %h", tag, ol, orr, sb[0]);
          end
          void'(sb.pop_front());
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
      end
    end
    checks++;
    if (valid !== 1'b0 || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drained: got valid=%b left=%0d expected valid=0 left=0", tag, valid, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (ovr !== 1'b0 || unr !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b%b expected 00", ovr, unr); end
    checks++; if (ol !== 16'h0 || orr !== 16'h0) begin errors++; $display("FAIL reset_data: got %h/%h expected 0000/0000", ol, orr); end
    rst = 1'b0;
    tick(6);
    checks++; if (level !== 3'd0 || valid_f !== 1'b0) begin errors++; $display("FAIL reset_idle: got %0d/%b expected 0/0", level, valid_f); end
  endtask

  task automatic test_latency();
    do_reset();
    dl = 16'h1234; dr = 16'hABCD; latch = 1'b1;
    sb.push_back(32'h1234ABCD);
    for (int k = 0; k < 3; k++) begin
      tick(1);
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL latency_early: edge %0d got valid=%b expected 0", k, valid); end
    end
    tick(1);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b expected 1", valid); end
    checks++; if (ol !== 16'h1234 || orr !== 16'hABCD) begin errors++; $display("FAIL latency_data: got %h/%h expected 1234/abcd", ol, orr); end
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL latency_level: got %0d expected 1", level); end
    tick(2);
    latch = 1'b0;
    tick(6);
    pop_all("latency");
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 1; i <= 5; i++) send_frame(16'(i), ~16'(i), i <= 4);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL overrun_level: got %0d expected 4", level); end
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b expected 1", ovr); end
    checks++; if (unr !== 1'b0) begin errors++; $display("FAIL overrun_unr: got %b expected 0", unr); end
    pop_all("overrun");
    checks++; if (ovr !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b expected 1", ovr); end
  endtask

  task automatic test_full_pop();
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(16'h0010 + 16'(i), 16'h0020 + 16'(i), 1'b1);
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_fill: got %0d expected 4", level); end
    dl = 16'h0099; dr = 16'h0088; latch = 1'b1;
    tick(3);
    checks++;
    if (valid !== 1'b1 || {ol, orr} !== sb[0]) begin
      errors++; $display("FAIL fullpop_head: got %b %h%h expected 1 %h", valid, ol, orr, sb[0]);
    end
    void'(sb.pop_front());
    sb.push_back(32'h00990088);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checks++; if (level !== 3'd4) begin errors++; $display("FAIL fullpop_level: got %0d expected 4", level); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL fullpop_ovr: got %b expected 0", ovr); end
    tick(2);
    latch = 1'b0;
    tick(5);
    pop_all("fullpop");
  endtask

  task automatic test_underrun();
    do_reset();
    send_frame(16'h7FFF, 16'h1111, 1'b1);
    pop_all("underrun_pop");
    ready = 1'b1;
    tick(3);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL underrun_valid: got %b expected 0", valid); end
    checks++; if (unr !== 1'b1) begin errors++; $display("FAIL underrun_flag: got %b expected 1", unr); end
    checks++; if (ol !== 16'h7FFF || orr !== 16'h1111) begin errors++; $display("FAIL underrun_hold: got %h/%h expected 7fff/1111", ol, orr); end
    checks++; if (ovr !== 1'b0) begin errors++; $display("FAIL underrun_ovr: got %b expected 0", ovr); end
    ready = 1'b0;
  endtask

  task automatic test_latch_high_reset();
    do_reset();
    send_frame(16'hDEAD, 16'hBEEF, 1'b0);
    send_frame(16'hCAFE, 16'hF00D, 1'b0);
    latch = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(8);
    checks++; if (level !== 3'd0 || valid !== 1'b0) begin errors++; $display("FAIL latchhigh_level: got %0d/%b expected 0/0", level, valid); end
    checks++; if (unr !== 1'b0 || ovr !== 1'b0) begin errors++; $display("FAIL latchhigh_flags: got %b%b expected 00", ovr, unr); end
    latch = 1'b0;
    tick(4);
    send_frame(16'h55AA, 16'hAA55, 1'b1);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL latchhigh_next: got %0d expected 1", level); end
    pop_all("latchhigh");
  endtask

  task automatic test_fall_random();
    int r;
    logic [15:0] nl, nr;
    do_reset();
    latch_f = 1'b1;
    tick(4);
    for (int fr = 0; fr < 1000; fr++) begin
      r = int'($urandom_range(1, 8));
      if (r >= 5) r++;
      #(r);
      nl = 16'($urandom);
      nr = 16'($urandom);
      dl_f = nl; dr_f = nr; latch_f = 1'b0;
      sb_f.push_back({nl, nr});
      @(negedge clk);
      tick(5);
      checks++;
      if (valid_f !== 1'b1) begin
        errors++; $display("FAIL fall_valid: frame %0d got %b expected 1", fr, valid_f);
      end else begin
        if ({ol_f, or_f} !== sb_f[0]) begin
          errors++; $display("FAIL fall_data: frame %0d got %h%h expected %h", fr, ol_f, or_f, sb_f[0]);
        end
        void'(sb_f.pop_front());
        ready_f = 1'b1;
        tick(1);
        ready_f = 1'b0;
      end
      latch_f = 1'b1;
      tick(4);
    end
    checks++; if (ovr_f !== 1'b0 || unr_f !== 1'b0) begin errors++; $display("FAIL fall_flags: got %b%b expected 00", ovr_f, unr_f); end
    checks++; if (level_f !== 3'd0 || sb_f.size() != 0) begin errors++; $display("FAIL fall_left: got %0d/%0d expected 0/0", level_f, sb_f.size()); end
  endtask

  initial begin
    rst = 1'b1; latch = 1'b0; ready = 1'b0; dl = '0; dr = '0;
    latch_f = 1'b0; ready_f = 1'b0; dl_f = '0; dr_f = '0;
    @(negedge clk);
    test_reset();
    test_latency();
    test_overrun();
    test_full_pop();
    test_underrun();
    test_latch_high_reset();
    test_fall_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
